// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared Sobel datapath constants and arbiter state type
package sobel_pkg;

  localparam int GRAD_W = 11;
  localparam int PIX_W  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    HOLD    = 2'd2
  } grad_arb_state_t;

endpackage

// File: rtl/gradient_arbiter_if.sv
// rtl/gradient_arbiter_if.sv - requester, total_gradient and result signals of gradient_arbiter
interface gradient_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int GRAD_W  = sobel_pkg::GRAD_W
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*GRAD_W-1:0]   req_gx;
  logic [NUM_REQ*GRAD_W-1:0]   req_gy;
  logic [NUM_REQ-1:0]          req_ready;
  logic [GRAD_W-1:0]           tg_gx;
  logic [GRAD_W-1:0]           tg_gy;
  logic [sobel_pkg::PIX_W-1:0] tg_g;
  logic                        out_valid;
  logic                        out_ready;
  logic [sobel_pkg::PIX_W-1:0] out_g;
  logic [ID_W-1:0]             out_id;

  modport slave (
    input  req_valid, req_gx, req_gy, tg_g, out_ready,
    output req_ready, tg_gx, tg_gy, out_valid, out_g, out_id
  );

  modport master (
    output req_valid, req_gx, req_gy, tg_g, out_ready,
    input  req_ready, tg_gx, tg_gy, out_valid, out_g, out_id
  );

endinterface

// File: rtl/gradient_arbiter_rr.sv
// rtl/gradient_arbiter_rr.sv - round-robin pick of the first valid requester at or after ptr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  logic found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_i[(int'(ptr_i) + k) % NUM_REQ]) begin
        found                                 = 1'b1;
        grant_o[(int'(ptr_i) + k) % NUM_REQ]  = 1'b1;
        idx_o                                 = ID_W'((int'(ptr_i) + k) % NUM_REQ);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/total_gradient.sv
// rtl/total_gradient.sv - floor(sqrt(gx^2 + gy^2)) saturated to PIX_W bits, combinational
module total_gradient #(
  parameter int GRAD_W = sobel_pkg::GRAD_W
) (
  input  logic [GRAD_W-1:0]           gx,
  input  logic [GRAD_W-1:0]           gy,
  output logic [sobel_pkg::PIX_W-1:0] g
);
  import sobel_pkg::*;

  localparam int SQ_W = 2 * GRAD_W;

  logic [GRAD_W-1:0] ax, ay;
  logic [SQ_W-1:0]   sum_sq, root, trial;

  assign ax = gx[GRAD_W-1] ? -gx : gx;
  assign ay = gy[GRAD_W-1] ? -gy : gy;

  // Bitwise square root: keep each candidate bit whose square still fits under the sum.
  always_comb begin
    sum_sq = SQ_W'(ax) * SQ_W'(ax) + SQ_W'(ay) * SQ_W'(ay);
    root   = '0;
    trial  = '0;
    for (int b = GRAD_W - 1; b >= 0; b--) begin
      trial = root | (SQ_W'(1) << b);
      if (trial * trial <= sum_sq) root = trial;
    end
    g = (root > SQ_W'(2 ** PIX_W - 1)) ? '1 : root[PIX_W-1:0];
  end

endmodule

// File: rtl/gradient_arbiter.sv
// rtl/gradient_arbiter.sv - shares one total_gradient unit among NUM_REQ Sobel pipelines
module gradient_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GRAD_W         = sobel_pkg::GRAD_W,
  parameter int COMPUTE_CYCLES = 1
) (
  input logic               clk,
  input logic               n_rst,
  gradient_arbiter_if.slave bus
);
  import sobel_pkg::*;

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = 4;

  grad_arb_state_t    state_q;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [GRAD_W-1:0]  tg_gx_q, tg_gy_q;
  logic [GRAD_W-1:0]  gx_sel, gy_sel;
  logic               out_valid_q;
  logic [PIX_W-1:0]   out_g_q;
  logic [ID_W-1:0]    out_id_q;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req_i   (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  assign gx_sel   = bus.req_gx[grant_idx*GRAD_W +: GRAD_W];
  assign gy_sel   = bus.req_gy[grant_idx*GRAD_W +: GRAD_W];
  assign rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  // HOLD returns to IDLE on handshake, so a new accept waits one cycle after it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      tg_gx_q     <= '0;
      tg_gy_q     <= '0;
      out_valid_q <= 1'b0;
      out_g_q     <= '0;
      out_id_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            tg_gx_q  <= gx_sel;
            tg_gy_q  <= gy_sel;
            out_id_q <= grant_idx;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= CNT_W'(COMPUTE_CYCLES - 1);
            state_q  <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            out_g_q     <= bus.tg_g;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_q == IDLE) ? grant : '0;
  assign bus.tg_gx     = tg_gx_q;
  assign bus.tg_gy     = tg_gy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_g     = out_g_q;
  assign bus.out_id    = out_id_q;

endmodule
